fetch_unit: RTL

- Program-counter and fetch stage directly upstream of instruction_memory.
- Drives the instruction memory address and captures the returned 8-bit instruction one cycle later.
- Buffers fetched instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush and a halt input that stops new fetches.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// PC / fetch stage: issues one address per cycle to a 1-cycle-latency instruction memory and
// buffers returned instructions with their PCs in a small shift FIFO toward decode.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       INSTR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [INSTR_W-1:0] ent_instr_q [BUF_DEPTH];
  logic [INSTR_W-1:0] ent_instr_d [BUF_DEPTH];
  logic [ADDR_W-1:0]  ent_pc_q [BUF_DEPTH];
  logic [ADDR_W-1:0]  ent_pc_d [BUF_DEPTH];

  logic pop, push, issue;
  int   wr_idx;

  always_comb begin
    pop    = (count_q != '0) && out_ready;
    push   = inflight_q && !redirect_valid;
    // Credit counts the in-flight response so a push can never find the buffer full.
    issue  = !halt && !redirect_valid &&
             ((int'(count_q) + int'(inflight_q) - int'(pop)) < int'(BUF_DEPTH));
    wr_idx = int'(count_q) - int'(pop);

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    ent_instr_d = ent_instr_q;
    ent_pc_d    = ent_pc_q;
    // On flush the head is left alone so the empty outputs hold their last values.
    if (pop && !redirect_valid) begin
      for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
        if (i + 1 < int'(count_q)) begin
          ent_instr_d[i] = ent_instr_q[i+1];
          ent_pc_d[i]    = ent_pc_q[i+1];
        end
      end
    end
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      if (push && i == wr_idx) begin
        ent_instr_d[i] = imem_instruction;
        ent_pc_d[i]    = inflight_pc_q;
      end
    end

    if (redirect_valid) begin
      count_d = '0;
    end else begin
      count_d = CntW'(int'(count_q) + int'(push) - int'(pop));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        ent_instr_q[i] <= '0;
        ent_pc_q[i]    <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      ent_instr_q   <= ent_instr_d;
      ent_pc_q      <= ent_pc_d;
    end
  end

  assign imem_address    = pc_q;
  assign out_valid       = (count_q != '0);
  assign out_instruction = ent_instr_q[0];
  assign out_pc          = ent_pc_q[0];

  no_overflow_a: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (count_q == CntW'(BUF_DEPTH))));

endmodule
